// File: rtl/sdram_fetch_pkg.sv
// Shared state encoding and burst arithmetic for the SDRAM line-fetch controller.
package sdram_fetch_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLR   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  localparam int unsigned SEG_WORDS_DEF  = 160;
  localparam int unsigned BURST_LEN_DEF  = 32;
  localparam int unsigned BURSTS_PER_SEG = SEG_WORDS_DEF / BURST_LEN_DEF;

  function automatic int unsigned bursts_per_seg(input int unsigned seg_words,
                                                 input int unsigned burst_len);
    return seg_words / burst_len;
  endfunction

endpackage

// File: rtl/frame_addr_ptr.sv
// Frame read pointer: loads a new base, advances one word per beat, and wraps
// back to the latched base after FRAME_WORDS words.
module frame_addr_ptr #(
  parameter int unsigned AW          = 23,
  parameter int unsigned FRAME_WORDS = 384000
) (
  input  logic          iCLK_W,
  input  logic          iRST,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] FRAME_LEN = AW'(FRAME_WORDS);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] ptr_inc;

  assign ptr_inc = ptr_q + AW'(1);

  always_ff @(posedge iCLK_W or posedge iRST) begin
    if (iRST) begin
      ptr_q  <= '0;
      base_q <= '0;
    end else if (load) begin
      ptr_q  <= load_addr;
      base_q <= load_addr;
    end else if (inc) begin
      ptr_q <= (ptr_inc == base_q + FRAME_LEN) ? base_q : ptr_inc;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sdram_line_fetch_ctrl.sv
// Sequences SDRAM read bursts that refill one line-RAM segment per fetch request,
// and restarts the frame read pointer on each vertical sync.
module sdram_line_fetch_ctrl
  import sdram_fetch_pkg::*;
#(
  parameter int unsigned SEG_WORDS   = SEG_WORDS_DEF,
  parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
  parameter int unsigned FRAME_WORDS = 384000,
  parameter int unsigned AW          = 23
) (
  input  logic          iCLK_W,
  input  logic          iRST,
  input  logic          iVS,
  input  logic [AW-1:0] iFRAME_BASE,
  input  logic          iREQ,
  output logic          oREQ_CLR,
  output logic          oRD_REQ,
  output logic [AW-1:0] oRD_ADDR,
  output logic [8:0]    oRD_LEN,
  input  logic          iRD_ACK,
  input  logic          iRD_VALID,
  output logic          oEN_W,
  output logic          oBUSY,
  output logic          oERR
);

  localparam int unsigned NBURST  = bursts_per_seg(SEG_WORDS, BURST_LEN);
  localparam int unsigned BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int unsigned BURST_W = $clog2(NBURST + 1);

  logic [1:0]         state_q, state_d;
  logic               vs_q;
  logic               restart_pend_q;
  logic [AW-1:0]      base_pend_q;
  logic               err_q;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d, beats_left;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               vs_rise;
  logic               ptr_load;
  logic               beat_valid;
  logic               last_beat;
  logic [AW-1:0]      ptr;

  assign vs_rise  = iVS & ~vs_q;
  assign ptr_load = (state_q == S_IDLE) & restart_pend_q;

  // A VALID arriving together with the ACK is the first beat of the burst.
  assign beat_valid = iRD_VALID &
                      ((state_q == S_DATA) | ((state_q == S_ISSUE) & iRD_ACK));
  assign beats_left = (state_q == S_ISSUE) ? BEAT_W'(BURST_LEN) : beat_cnt_q;
  assign last_beat  = beat_valid & (beats_left == BEAT_W'(1));

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!restart_pend_q && iREQ) state_d = S_CLR;
      end
      S_CLR: begin
        burst_cnt_d = BURST_W'(NBURST);
        state_d     = S_ISSUE;
      end
      S_ISSUE, S_DATA: begin
        if ((state_q == S_ISSUE) && iRD_ACK) begin
          state_d    = S_DATA;
          beat_cnt_d = BEAT_W'(BURST_LEN);
        end
        if (beat_valid) begin
          beat_cnt_d = beats_left - BEAT_W'(1);
          if (last_beat) begin
            burst_cnt_d = burst_cnt_q - BURST_W'(1);
            state_d     = (burst_cnt_q == BURST_W'(1)) ? S_IDLE : S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_W or posedge iRST) begin
    if (iRST) begin
      state_q        <= S_IDLE;
      vs_q           <= 1'b0;
      restart_pend_q <= 1'b0;
      base_pend_q    <= '0;
      err_q          <= 1'b0;
      beat_cnt_q     <= '0;
      burst_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      vs_q           <= iVS;
      restart_pend_q <= vs_rise | (restart_pend_q & ~ptr_load);
      beat_cnt_q     <= beat_cnt_d;
      burst_cnt_q    <= burst_cnt_d;
      if (vs_rise) base_pend_q <= iFRAME_BASE;
      if (iRD_VALID && !beat_valid) err_q <= 1'b1;
    end
  end

  frame_addr_ptr #(
    .AW          (AW),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_frame_addr_ptr (
    .iCLK_W    (iCLK_W),
    .iRST      (iRST),
    .load      (ptr_load),
    .load_addr (base_pend_q),
    .inc       (beat_valid),
    .ptr       (ptr)
  );

  assign oREQ_CLR = (state_q == S_CLR);
  assign oRD_REQ  = (state_q == S_ISSUE);
  assign oRD_ADDR = oRD_REQ ? ptr : '0;
  assign oRD_LEN  = oRD_REQ ? 9'(BURST_LEN) : '0;
  assign oEN_W    = beat_valid;
  assign oBUSY    = (state_q != S_IDLE);
  assign oERR     = err_q;

endmodule
